// File: rtl/bin_to_decimal_pkg.sv
// Shared constants and types for the binary-to-BCD scoreboard converter.
package bin_to_decimal_pkg;

    localparam int BIN_W   = 7;
    localparam int DIGIT_W = 4;
    localparam int N_ITER  = BIN_W;
    localparam int CNT_W   = $clog2(N_ITER);
    localparam int MAX_DEC = 99;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bin_to_decimal_bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3
    import bin_to_decimal_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    assign d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin_to_decimal.sv
// Iterative 7-bit binary to two-digit BCD converter, one bit per cycle.
// Define BIN_TO_DECIMAL_CLAMP_EN to saturate inputs above 99 to 99.
module bin_to_decimal
    import bin_to_decimal_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BIN_W-1:0]   bin_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o
);

    logic [BIN_W-1:0]     shift_q;
    logic [2*DIGIT_W-1:0] bcd_q;
    logic [CNT_W-1:0]     cnt_q;

    bcd_digit_t           ones_fix;
    bcd_digit_t           tens_fix;
    logic [2*DIGIT_W-1:0] bcd_nxt;
    logic [BIN_W-1:0]     shift_nxt;
    logic [BIN_W-1:0]     bin_sampled;
    logic                 last_iter;

    bcd_add3 u_add3_ones (
        .d_i (bcd_q[DIGIT_W-1:0]),
        .d_o (ones_fix)
    );

    bcd_add3 u_add3_tens (
        .d_i (bcd_q[2*DIGIT_W-1:DIGIT_W]),
        .d_o (tens_fix)
    );

    // tens_fix[3] is the hundreds bit; dropping it yields value mod 100
    // because higher digits never feed back into lower ones.
    assign bcd_nxt   = {tens_fix[DIGIT_W-2:0], ones_fix, shift_q[BIN_W-1]};
    assign shift_nxt = {shift_q[BIN_W-2:0], 1'b0};
    assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

`ifdef BIN_TO_DECIMAL_CLAMP_EN
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_DEC);

    assign bin_sampled = (bin_i > MAX_BIN) ? MAX_BIN : bin_i;
`else
    assign bin_sampled = bin_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_o  <= '0;
            ones_o  <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (last_iter) begin
            tens_o  <= bcd_nxt[2*DIGIT_W-1:DIGIT_W];
            ones_o  <= bcd_nxt[DIGIT_W-1:0];
            shift_q <= bin_sampled;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_nxt;
            bcd_q   <= bcd_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bin_to_decimal.sv
// Bench for bin_to_decimal: table vectors, sweep, frame timing, random model.
module tb_bin_to_decimal;

    logic       clk;
    logic       rst_i;
    logic [6:0] bin_i;
    logic [3:0] tens_o;
    logic [3:0] ones_o;

    int vectors;
    int errors;

    // reference model state: frame phase and the two-stage digit pipeline
    int         n_edge;
    logic [3:0] pend_t, pend_o;
    logic [3:0] exp_t, exp_o;

    typedef struct {
        logic [6:0] bin;
        logic [3:0] tens;
        logic [3:0] ones;
    } vec_t;

    vec_t vecs[8];

    bin_to_decimal dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .bin_i  (bin_i),
        .tens_o (tens_o),
        .ones_o (ones_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic void ref_digits(input logic [6:0] b,
                                       output logic [3:0] t,
                                       output logic [3:0] o);
        int v;
        v = int'(b);
`ifdef BIN_TO_DECIMAL_CLAMP_EN
        if (v > 99) v = 99;
`else
        v = v % 100;
`endif
        t = 4'(v / 10);
        o = 4'(v % 10);
    endfunction

    task automatic step();
        logic [6:0] b;
        logic       r;
        b = bin_i;
        r = rst_i;
        @(posedge clk);
        #1;
        if (r) begin
            n_edge = 0;
            pend_t = '0;
            pend_o = '0;
            exp_t  = '0;
            exp_o  = '0;
        end else begin
            n_edge++;
            if (n_edge % 7 == 0) begin
                exp_t = pend_t;
                exp_o = pend_o;
                ref_digits(b, pend_t, pend_o);
            end
        end
    endtask

    task automatic check(input string name,
                         input logic [3:0] et,
                         input logic [3:0] eo);
        vectors++;
        if (tens_o !== et || ones_o !== eo) begin
            errors++;
            $display("FAIL %s: bin=%0d got %0d/%0d expected %0d/%0d",
                     name, bin_i, tens_o, ones_o, et, eo);
        end
    endtask

    task automatic hold_check(input string name,
                              input logic [6:0] b,
                              input logic [3:0] et,
                              input logic [3:0] eo);
        bin_i = b;
        repeat (14) step();
        check(name, et, eo);
    endtask

    initial begin
        logic [3:0] t, o;
        bit         found;

        vectors = 0;
        errors  = 0;
        n_edge  = 0;
        pend_t  = '0;
        pend_o  = '0;
        exp_t   = '0;
        exp_o   = '0;

        vecs[0] = '{7'd5,   4'd0, 4'd5};
        vecs[1] = '{7'd15,  4'd1, 4'd5};
        vecs[2] = '{7'd42,  4'd4, 4'd2};
        vecs[3] = '{7'd99,  4'd9, 4'd9};
        vecs[4] = '{7'd0,   4'd0, 4'd0};
        vecs[5] = '{7'd73,  4'd7, 4'd3};
`ifdef BIN_TO_DECIMAL_CLAMP_EN
        vecs[6] = '{7'd127, 4'd9, 4'd9};
        vecs[7] = '{7'd100, 4'd9, 4'd9};
`else
        vecs[6] = '{7'd127, 4'd2, 4'd7};
        vecs[7] = '{7'd100, 4'd0, 4'd0};
`endif

        rst_i = 1'b1;
        bin_i = 7'd0;
        repeat (2) begin
            step();
            check("reset", 4'd0, 4'd0);
        end
        rst_i = 1'b0;
        repeat (15) begin
            step();
            check("zero_after_reset", 4'd0, 4'd0);
        end

        foreach (vecs[i]) begin
            hold_check("table", vecs[i].bin, vecs[i].tens, vecs[i].ones);
            step();
        end

        hold_check("pre_reset", 7'd42, 4'd4, 4'd2);
        rst_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) bin_i = 7'd99;
            step();
            check("reset_mid", 4'd0, 4'd0);
        end
        rst_i = 1'b0;
        hold_check("after_reset", 7'd73, 4'd7, 4'd3);
        step();

        for (int v = 0; v < 100; v++) begin
            bin_i = 7'(v);
            repeat (14) step();
            check("sweep", 4'(v / 10), 4'(v % 10));
        end

        hold_check("frame_pre", 7'd11, 4'd1, 4'd1);
        bin_i = 7'd22;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tens_o == 4'd2 && ones_o == 4'd2) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL frame_find: got %0d/%0d expected 2/2 within 20 cycles",
                     tens_o, ones_o);
        end
        bin_i = 7'd33;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k < 14) check("frame_hold", 4'd2, 4'd2);
            else        check("frame_update", 4'd3, 4'd3);
        end

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) bin_i = 7'($urandom_range(0, 127));
            step();
            check("random_model", exp_t, exp_o);
        end

        ref_digits(7'd127, t, o);
        hold_check("model_127", 7'd127, t, o);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
